// File: rtl/wb_resp_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the Wishbone register-bank responder.
package wb_resp_pkg;

   localparam logic [31:0] ID_DEFAULT = 32'h55534244;

   localparam logic [13:0] OFF_ID         = 14'h0000;
   localparam logic [13:0] OFF_SCRATCH0   = 14'h0004;
   localparam logic [13:0] OFF_SCRATCH1   = 14'h0008;
   localparam logic [13:0] OFF_COUNTER    = 14'h000C;
   localparam logic [13:0] OFF_IRQ_STATUS = 14'h0010;
   localparam logic [13:0] OFF_IRQ_ENABLE = 14'h0014;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2
   } wb_state_t;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
      return (old_val & ~mask) | (new_val & mask);
   endfunction

endpackage

// File: rtl/wb_resp_irq_unit.sv
// Interrupt block: rising-edge capture into W1C status, enable mask, registered irq output.
module wb_resp_irq_unit #(
   parameter int IRQ_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IRQ_W-1:0] irq_in,
   input  logic             status_we,
   input  logic             enable_we,
   input  logic [IRQ_W-1:0] wr_data,
   input  logic [IRQ_W-1:0] wr_mask,
   output logic [IRQ_W-1:0] status,
   output logic [IRQ_W-1:0] enable,
   output logic             irq
);

   logic [IRQ_W-1:0] irq_prev;
   logic [IRQ_W-1:0] rise;
   logic [IRQ_W-1:0] clr;

   assign rise = irq_in & ~irq_prev;
   assign clr  = status_we ? (wr_data & wr_mask) : '0;

   // Set is OR-ed in after the clear so a coincident edge survives the W1C.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_prev <= '0;
         status   <= '0;
         enable   <= '0;
         irq      <= 1'b0;
      end else begin
         irq_prev <= irq_in;
         status   <= (status & ~clr) | rise;
         if (enable_we) begin
            enable <= (enable & ~wr_mask) | (wr_data & wr_mask);
         end
         irq <= |(status & enable);
      end
   end

endmodule

// File: rtl/wb_resp_regbank.sv
// Wishbone classic responder with ID, scratch, free-running counter and interrupt registers.
// Optional macro WB_RESP_ERR_EN adds wb_ERR for unmapped accesses and writes to ID.
module wb_resp_regbank
   import wb_resp_pkg::*;
#(
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] ID_VALUE    = ID_DEFAULT,
   parameter int          IRQ_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wb_CYC,
   input  logic             wb_STB,
   input  logic             wb_WE,
   input  logic [13:0]      wb_ADR,
   input  logic [3:0]       wb_SEL,
   input  logic [31:0]      wb_DAT_MOSI,
   output logic [31:0]      wb_DAT_MISO,
   output logic             wb_ACK,
`ifdef WB_RESP_ERR_EN
   output logic             wb_ERR,
`endif
   input  logic [IRQ_W-1:0] irq_in,
   output logic             irq
);

   localparam logic [3:0] WS_M1 = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   wb_state_t   state, state_nx;
   logic [3:0]  wait_cnt, wait_cnt_nx;
   logic        accept;
   logic        commit;

   logic [13:0] adr_q;
   logic        we_q;
   logic [3:0]  sel_q;
   logic [31:0] dat_q;

   logic [31:0] scratch0, scratch1, counter;
   logic [31:0] mask;
   logic [31:0] rd_data;
   logic [31:0] status32, enable32;
   logic [13:0] addr_w;
   logic        hit_id, hit_s0, hit_s1, hit_cnt, hit_st, hit_en;
   logic        wr_ok;

   logic [IRQ_W-1:0] irq_status, irq_enable;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wb_CYC && wb_STB) begin
               accept = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_nx = ST_ACK;
               end else begin
                  state_nx    = ST_WAIT;
                  wait_cnt_nx = WS_M1;
               end
            end
         end
         ST_WAIT: begin
            if (!(wb_CYC && wb_STB)) begin
               state_nx = ST_IDLE;
            end else if (wait_cnt == 4'd0) begin
               state_nx = ST_ACK;
            end else begin
               wait_cnt_nx = wait_cnt - 4'd1;
            end
         end
         ST_ACK:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // The edge leaving ST_ACK is the one that commits writes and raises wb_ACK.
   assign commit = (state == ST_ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q <= '0;
         we_q  <= 1'b0;
         sel_q <= '0;
         dat_q <= '0;
      end else if (accept) begin
         adr_q <= wb_ADR;
         we_q  <= wb_WE;
         sel_q <= wb_SEL;
         dat_q <= wb_DAT_MOSI;
      end
   end

   assign addr_w  = adr_q & 14'h3FFC;
   assign hit_id  = (addr_w == OFF_ID);
   assign hit_s0  = (addr_w == OFF_SCRATCH0);
   assign hit_s1  = (addr_w == OFF_SCRATCH1);
   assign hit_cnt = (addr_w == OFF_COUNTER);
   assign hit_st  = (addr_w == OFF_IRQ_STATUS);
   assign hit_en  = (addr_w == OFF_IRQ_ENABLE);
   assign wr_ok   = commit && we_q;
   assign mask    = lane_mask(sel_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scratch0 <= '0;
         scratch1 <= '0;
         counter  <= '0;
      end else begin
         if (wr_ok && hit_s0) scratch0 <= merge_lanes(scratch0, dat_q, mask);
         if (wr_ok && hit_s1) scratch1 <= merge_lanes(scratch1, dat_q, mask);
         if (wr_ok && hit_cnt) begin
            counter <= merge_lanes(counter, dat_q, mask);
         end else begin
            counter <= counter + 32'd1;
         end
      end
   end

   wb_resp_irq_unit #(.IRQ_W(IRQ_W)) u_irq (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_in    (irq_in),
      .status_we (wr_ok && hit_st),
      .enable_we (wr_ok && hit_en),
      .wr_data   (dat_q[IRQ_W-1:0]),
      .wr_mask   (mask[IRQ_W-1:0]),
      .status    (irq_status),
      .enable    (irq_enable),
      .irq       (irq)
   );

   always_comb begin
      status32             = '0;
      enable32             = '0;
      status32[IRQ_W-1:0]  = irq_status;
      enable32[IRQ_W-1:0]  = irq_enable;
      rd_data              = '0;
      if (hit_id)  rd_data = ID_VALUE;
      if (hit_s0)  rd_data = scratch0;
      if (hit_s1)  rd_data = scratch1;
      if (hit_cnt) rd_data = counter;
      if (hit_st)  rd_data = status32;
      if (hit_en)  rd_data = enable32;
   end

`ifdef WB_RESP_ERR_EN
   logic err_access;
   assign err_access = !(hit_id || hit_s0 || hit_s1 || hit_cnt || hit_st || hit_en)
                       || (we_q && hit_id);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ACK      <= 1'b0;
         wb_ERR      <= 1'b0;
         wb_DAT_MISO <= '0;
      end else begin
         wb_ACK      <= commit && !err_access;
         wb_ERR      <= commit && err_access;
         wb_DAT_MISO <= (commit && !we_q) ? rd_data : '0;
      end
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_ACK      <= 1'b0;
         wb_DAT_MISO <= '0;
      end else begin
         wb_ACK      <= commit;
         wb_DAT_MISO <= (commit && !we_q) ? rd_data : '0;
      end
   end
`endif

endmodule

// File: tb/tb_wb_resp_regbank.sv
// Directed bench for wb_resp_regbank: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
module tb_wb_resp_regbank;
   import wb_resp_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc_a = 1'b0, cyc_b = 1'b0;
   logic        stb = 1'b0, we = 1'b0;
   logic [13:0] adr = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat_mosi = '0;
   logic [31:0] miso_a, miso_b;
   logic        ack_a, ack_b;
   logic        resp_a, resp_b;
   logic [3:0]  irq_in_a = '0, irq_in_b = '0;
   logic        irq_a, irq_b;
   int          edge_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) edge_n <= edge_n + 1;

`ifdef WB_RESP_ERR_EN
   logic err_a, err_b;
   assign resp_a = ack_a | err_a;
   assign resp_b = ack_b | err_b;
`else
   assign resp_a = ack_a;
   assign resp_b = ack_b;
`endif

   wb_resp_regbank #(.WAIT_STATES(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .wb_CYC(cyc_a), .wb_STB(stb), .wb_WE(we),
      .wb_ADR(adr), .wb_SEL(sel), .wb_DAT_MOSI(dat_mosi), .wb_DAT_MISO(miso_a),
      .wb_ACK(ack_a),
`ifdef WB_RESP_ERR_EN
      .wb_ERR(err_a),
`endif
      .irq_in(irq_in_a), .irq(irq_a)
   );

   wb_resp_regbank #(.WAIT_STATES(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .wb_CYC(cyc_b), .wb_STB(stb), .wb_WE(we),
      .wb_ADR(adr), .wb_SEL(sel), .wb_DAT_MOSI(dat_mosi), .wb_DAT_MISO(miso_b),
      .wb_ACK(ack_b),
`ifdef WB_RESP_ERR_EN
      .wb_ERR(err_b),
`endif
      .irq_in(irq_in_b), .irq(irq_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // d selects the instance (0: WAIT_STATES=1, 1: WAIT_STATES=3); returns at the response edge + 1.
   task automatic wb_xfer(input int d, input logic w, input logic [13:0] a, input logic [3:0] s,
                          input logic [31:0] wd, output logic [31:0] rd, output int lat,
                          output int at);
      logic r;
      @(negedge clk);
      cyc_a = (d == 0); cyc_b = (d != 0); stb = 1'b1; we = w; adr = a; sel = s; dat_mosi = wd;
      @(posedge clk); #1;
      lat = -1; at = -1; rd = '0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         r = (d == 0) ? resp_a : resp_b;
         if (r) begin
            lat = k;
            at  = edge_n;
            rd  = (d == 0) ? miso_a : miso_b;
            break;
         end
      end
      cyc_a = 1'b0; cyc_b = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int lat, at_w, at_r;
      logic seen;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack_a", 32'(ack_a), 32'd0);
      check("rst_miso_a", miso_a, 32'd0);
      check("rst_irq_a", 32'(irq_a), 32'd0);
      check("rst_ack_b", 32'(ack_b), 32'd0);
      @(negedge clk); rst_n = 1'b1;

      // ID read: latency, data, and MISO/ACK back to 0 a cycle later
      exp_q.push_back(32'h55534244);
      wb_xfer(0, 1'b0, 14'h0000, 4'hF, 32'h0, rd, lat, at_r);
      check("id_lat", 32'(lat), 32'd2);
      check("id_data", rd, exp_q.pop_front());
      @(posedge clk); #1;
      check("id_ack_drop", 32'(ack_a), 32'd0);
      check("id_miso_drop", miso_a, 32'd0);

      // Partial-lane scratch write
      wb_xfer(0, 1'b1, 14'h0004, 4'b0101, 32'hA5A5A5A5, rd, lat, at_w);
      check("s0_wr_lat", 32'(lat), 32'd2);
      check("s0_wr_miso", rd, 32'd0);
      exp_q.push_back(32'h00A500A5);
      wb_xfer(0, 1'b0, 14'h0004, 4'hF, 32'h0, rd, lat, at_r);
      check("s0_rd", rd, exp_q.pop_front());

      // Full scratch1 write, with ignored low address bits on the read
      wb_xfer(0, 1'b1, 14'h0008, 4'hF, 32'h12345678, rd, lat, at_w);
      exp_q.push_back(32'h12345678);
      wb_xfer(0, 1'b0, 14'h000B, 4'hF, 32'h0, rd, lat, at_r);
      check("s1_rd", rd, exp_q.pop_front());

      // Counter wrap: value at read edge = loaded value + edges elapsed since the load edge - 1
      wb_xfer(0, 1'b1, 14'h000C, 4'hF, 32'hFFFFFFFE, rd, lat, at_w);
      repeat (3) @(posedge clk);
      wb_xfer(0, 1'b0, 14'h000C, 4'hF, 32'h0, rd, lat, at_r);
      check("cnt_gap", 32'(at_r - at_w), 32'd6);
      check("cnt_wrap", rd, 32'hFFFFFFFE + 32'(at_r - at_w - 1));

      // IRQ: enable bit 2, pulse irq_in[2]
      wb_xfer(0, 1'b1, 14'h0014, 4'hF, 32'h4, rd, lat, at_w);
      check("irq_pre", 32'(irq_a), 32'd0);
      @(posedge clk); #1 irq_in_a = 4'b0100;
      @(posedge clk); #1;
      @(posedge clk); #1 irq_in_a = 4'b0000;
      check("irq_set", 32'(irq_a), 32'd1);
      exp_q.push_back(32'h4);
      wb_xfer(0, 1'b0, 14'h0010, 4'hF, 32'h0, rd, lat, at_r);
      check("status_set", rd, exp_q.pop_front());
      exp_q.push_back(32'h4);
      wb_xfer(0, 1'b0, 14'h0014, 4'hF, 32'h0, rd, lat, at_r);
      check("enable_rd", rd, exp_q.pop_front());

      // W1C arriving on the same edge as a new irq_in[2] rise: set wins
      @(negedge clk);
      cyc_a = 1'b1; stb = 1'b1; we = 1'b1; adr = 14'h0010; sel = 4'hF; dat_mosi = 32'h4;
      @(posedge clk); #1;
      @(posedge clk); #1 irq_in_a = 4'b0100;
      @(posedge clk); #1;
      check("w1c_race_ack", 32'(ack_a), 32'd1);
      cyc_a = 1'b0; stb = 1'b0; we = 1'b0;
      exp_q.push_back(32'h4);
      wb_xfer(0, 1'b0, 14'h0010, 4'hF, 32'h0, rd, lat, at_r);
      check("w1c_set_wins", rd, exp_q.pop_front());
      check("irq_hold", 32'(irq_a), 32'd1);

      // Plain W1C clears status; irq falls one cycle later
      irq_in_a = 4'b0000;
      wb_xfer(0, 1'b1, 14'h0010, 4'hF, 32'h4, rd, lat, at_w);
      @(posedge clk); #1;
      check("irq_clr", 32'(irq_a), 32'd0);
      exp_q.push_back(32'h0);
      wb_xfer(0, 1'b0, 14'h0010, 4'hF, 32'h0, rd, lat, at_r);
      check("status_clr", rd, exp_q.pop_front());

      // Unmapped read and write to ID
      wb_xfer(0, 1'b0, 14'h03FC, 4'hF, 32'h0, rd, lat, at_r);
      check("unmap_lat", 32'(lat), 32'd2);
      check("unmap_miso", rd, 32'd0);
`ifdef WB_RESP_ERR_EN
      check("unmap_ack", 32'(ack_a), 32'd0);
      check("unmap_err", 32'(err_a), 32'd1);
`else
      check("unmap_ack", 32'(ack_a), 32'd1);
`endif
      wb_xfer(0, 1'b1, 14'h0000, 4'hF, 32'hFFFFFFFF, rd, lat, at_w);
`ifdef WB_RESP_ERR_EN
      check("id_wr_err", 32'(err_a), 32'd1);
`else
      check("id_wr_ack", 32'(ack_a), 32'd1);
`endif
      exp_q.push_back(32'h55534244);
      wb_xfer(0, 1'b0, 14'h0000, 4'hF, 32'h0, rd, lat, at_r);
      check("id_ro", rd, exp_q.pop_front());

      // WAIT_STATES=3: abort a scratch1 write by dropping STB during WAIT
      @(negedge clk);
      cyc_b = 1'b1; stb = 1'b1; we = 1'b1; adr = 14'h0008; sel = 4'hF; dat_mosi = 32'hDEADBEEF;
      @(posedge clk); #1;
      @(posedge clk); #1 stb = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         if (ack_b) seen = 1'b1;
      end
      check("abort_no_ack", 32'(seen), 32'd0);
      cyc_b = 1'b0; we = 1'b0;
      exp_q.push_back(32'h0);
      wb_xfer(1, 1'b0, 14'h0008, 4'hF, 32'h0, rd, lat, at_r);
      check("ws3_lat", 32'(lat), 32'd4);
      check("abort_s1", rd, exp_q.pop_front());

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
